// File: rtl/freelist_ctrl.sv
// Physical-register free list for a 2-wide rename stage: allocates new tags,
// reclaims stale tags at retire, and restores the retired state on rollback.
// Optional stall counter enabled by defining FREELIST_PERF_CNT_EN.
module freelist_ctrl #(
    parameter  int PHYS_REGS = 64,
    parameter  int ARCH_REGS = 32,
    parameter  int SCALAR    = 2,
    localparam int PREG_W    = $clog2(PHYS_REGS),
    localparam int DEPTH     = PHYS_REGS - ARCH_REGS,
    localparam int PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           rollback_i,
    input  logic [SCALAR-1:0]              alloc_req_i,
    output logic                           alloc_gnt_o,
    output logic [SCALAR-1:0][PREG_W-1:0]  alloc_tag_o,
    input  logic [SCALAR-1:0]              retire_valid_i,
    input  logic [SCALAR-1:0][PREG_W-1:0]  retire_told_i,
    output logic [PTR_W-1:0]               free_cnt_o,
    output logic                           overflow_err_o,
    output logic [31:0]                    stall_cycles_o
);
    localparam int IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] fl_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  arch_head_q, arch_head_d;
    logic              overflow_q;

    logic [PTR_W-1:0]  n_req_s, k_s, free_cnt_s, room_s, n_wr_s;
    logic              ovf_s;
    logic [SCALAR-1:0]             wr_en_s;
    logic [SCALAR-1:0][IDX_W-1:0]  wr_idx_s;

    function automatic logic [PTR_W-1:0] popcnt(input logic [SCALAR-1:0] v);
        logic [PTR_W-1:0] c;
        c = '0;
        for (int i = 0; i < SCALAR; i++) c = c + PTR_W'(v[i]);
        return c;
    endfunction

    // Occupancy, grant decision and tags offered at the head of the list.
    always_comb begin
        n_req_s     = popcnt(alloc_req_i);
        k_s         = popcnt(retire_valid_i);
        free_cnt_s  = tail_q - head_q;
        room_s      = PTR_W'(DEPTH) - free_cnt_s;
        ovf_s       = (k_s > room_s);
        n_wr_s      = ovf_s ? room_s : k_s;
        alloc_gnt_o = !reset_i && !rollback_i && (free_cnt_s >= n_req_s);
        for (int i = 0; i < SCALAR; i++) begin
            alloc_tag_o[i] = fl_q[head_q[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    // Compact valid retire slots onto consecutive tail positions; writes past the room are dropped.
    always_comb begin : write_slots
        logic [PTR_W-1:0] off;
        off = '0;
        for (int j = 0; j < SCALAR; j++) begin
            wr_en_s[j]  = retire_valid_i[j] && (off < n_wr_s);
            wr_idx_s[j] = tail_q[IDX_W-1:0] + off[IDX_W-1:0];
            off         = off + PTR_W'(retire_valid_i[j]);
        end
    end

    // Pointer next-state; rollback rewinds head to the retired point (including this cycle's retires).
    always_comb begin
        tail_d      = tail_q + n_wr_s;
        arch_head_d = arch_head_q + k_s;
        if (rollback_i) begin
            head_d = arch_head_q + k_s;
        end else if (alloc_gnt_o) begin
            head_d = head_q + n_req_s;
        end else begin
            head_d = head_q;
        end
    end

    // List storage, pointers and sticky overflow flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) fl_q[i] <= PREG_W'(ARCH_REGS + i);
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= {1'b1, {IDX_W{1'b0}}};
            overflow_q  <= 1'b0;
        end else begin
            for (int j = 0; j < SCALAR; j++) begin
                if (wr_en_s[j]) fl_q[wr_idx_s[j]] <= retire_told_i[j];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            arch_head_q <= arch_head_d;
            overflow_q  <= overflow_q | ovf_s;
        end
    end

    assign free_cnt_o     = free_cnt_s;
    assign overflow_err_o = overflow_q;

`ifdef FREELIST_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where rename asked for tags and was refused.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_q <= 32'd0;
        end else if ((n_req_s != '0) && !alloc_gnt_o && !rollback_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl: a free-queue / in-flight-queue model
// predicts grants and tags; expected tags go through a scoreboard queue.
module tb_freelist_ctrl;
    logic             clock, reset, rollback;
    logic [1:0]       alloc_req, retire_valid;
    logic [1:0][5:0]  retire_told, alloc_tag;
    logic             alloc_gnt, overflow_err;
    logic [5:0]       free_cnt;
    logic [31:0]      stall_cycles;

    int fq[$];
    int ifq[$];
    int exp_tags[$];
    int exp_ovf, exp_stall;
    int errors, checks;

    freelist_ctrl dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .rollback_i     (rollback),
        .alloc_req_i    (alloc_req),
        .alloc_gnt_o    (alloc_gnt),
        .alloc_tag_o    (alloc_tag),
        .retire_valid_i (retire_valid),
        .retire_told_i  (retire_told),
        .free_cnt_o     (free_cnt),
        .overflow_err_o (overflow_err),
        .stall_cycles_o (stall_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        ifq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(32 + i);
        exp_ovf   = 0;
        exp_stall = 0;
    endtask

    // Reset is held for one cycle with conflicting traffic to show it dominates.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; rollback = 1'b1; alloc_req = 2'b11; retire_valid = 2'b11;
        retire_told[0] = 6'd1; retire_told[1] = 6'd2;
        #1;
        check("gnt_in_reset", {31'd0, alloc_gnt}, 32'd0);
        @(posedge clock);
        model_reset();
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] rv, input int t0, input int t1,
                        input logic rb, input string name);
        int nreq, k, pre, pushed, t;
        logic exp_gnt;
        @(negedge clock);
        reset = 1'b0; rollback = rb; alloc_req = req; retire_valid = rv;
        retire_told[0] = 6'(t0); retire_told[1] = 6'(t1);
        nreq    = int'(req[0]) + int'(req[1]);
        k       = int'(rv[0]) + int'(rv[1]);
        exp_gnt = !rb && (fq.size() >= nreq);
        if (exp_gnt) for (int i = 0; i < nreq; i++) exp_tags.push_back(fq[i]);
        #1;
        check({name, "_gnt"}, {31'd0, alloc_gnt}, {31'd0, exp_gnt});
        check({name, "_free_cnt"}, {26'd0, free_cnt}, fq.size());
        check({name, "_ovf"}, {31'd0, overflow_err}, exp_ovf);
        check({name, "_stall"}, stall_cycles, exp_stall);
        if (exp_gnt) begin
            for (int i = 0; i < nreq; i++) begin
                t = exp_tags.pop_front();
                check({name, "_tag"}, {26'd0, alloc_tag[i]}, t);
            end
        end
        @(posedge clock);
        pre = fq.size();
        pushed = 0;
        if (exp_gnt) for (int i = 0; i < nreq; i++) ifq.push_back(fq.pop_front());
`ifdef FREELIST_PERF_CNT_EN
        if (nreq > 0 && !exp_gnt && !rb) exp_stall++;
`endif
        for (int j = 0; j < 2; j++) begin
            if (rv[j]) begin
                if (ifq.size() > 0) void'(ifq.pop_front());
                if (pushed < 32 - pre) begin
                    fq.push_back(j == 0 ? t0 : t1);
                    pushed++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
        if (rb) begin
            for (int i = ifq.size() - 1; i >= 0; i--) fq.push_front(ifq[i]);
            ifq.delete();
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0; rollback = 1'b0; alloc_req = 2'b00; retire_valid = 2'b00;
        retire_told = '0;
        model_reset();

        // Reset state and first pair of tags.
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0, "first_pair");
        step(2'b00, 2'b00, 0, 0, 1'b0, "after_first");

        // Drain the list completely, then stall on an empty list.
        do_reset();
        for (int p = 0; p < 16; p++) step(2'b11, 2'b00, 0, 0, 1'b0, "drain");
        step(2'b01, 2'b00, 0, 0, 1'b0, "empty_stall");

        // Retire into an empty list while requesting: freed tags not visible until next cycle.
        step(2'b01, 2'b11, 7, 5, 1'b0, "no_bypass");
        step(2'b01, 2'b00, 0, 0, 1'b0, "after_free");
        step(2'b11, 2'b00, 0, 0, 1'b0, "mixed");

        // Speculative allocation followed by rollback with a concurrent retire.
        do_reset();
        for (int p = 0; p < 3; p++) step(2'b11, 2'b00, 0, 0, 1'b0, "spec_alloc");
        step(2'b00, 2'b11, 2, 1, 1'b0, "retire_two");
        step(2'b11, 2'b01, 3, 0, 1'b1, "rollback");
        step(2'b11, 2'b00, 0, 0, 1'b0, "post_rollback");
        step(2'b01, 2'b10, 0, 9, 1'b0, "post_rb_retire_slot1");

        // Steady alloc/retire across the index wrap.
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0, "wrap_fill");
        step(2'b11, 2'b00, 0, 0, 1'b0, "wrap_fill");
        for (int p = 0; p < 40; p++) step(2'b01, 2'b01, (p * 7 + 3) % 64, 0, 1'b0, "wrap");
        step(2'b00, 2'b00, 0, 0, 1'b0, "wrap_end");

        // Free into a full list sets the sticky overflow; reset clears it.
        do_reset();
        step(2'b00, 2'b01, 9, 0, 1'b0, "overflow");
        step(2'b01, 2'b00, 0, 0, 1'b0, "overflow_hold");
        do_reset();
        step(2'b00, 2'b00, 0, 0, 1'b0, "overflow_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freelist_ctrl.md
Name: freelist_ctrl

Overview:
- Physical-register free-list controller for the 2-wide rename stage.
- Hands up to SCALAR free physical tags per cycle to rename. Those tags become the new mappings written into the RAT.
- Reclaims stale tags (T_old) as instructions retire.
- On rollback, restores the list to the architectural (retired) state, consistent with the RAT being reloaded from the RRAT.

Parameters:
- PHYS_REGS, 64, number of physical registers; tag width PREG_W = $clog2(PHYS_REGS).
- ARCH_REGS, 32, number of architectural registers; tags 0..ARCH_REGS-1 are mapped at reset and never start in the list.
- SCALAR, 2, allocate/free ports per cycle.
- DEPTH (local), PHYS_REGS-ARCH_REGS = 32; pointer width PTR_W = $clog2(DEPTH)+1 (MSB is the wrap bit).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rollback  in  1  flush; same-cycle partner of the RAT rollback
- alloc_req  in  SCALAR  per-slot request for a new tag; slots are compacted, so alloc_req[1] may only be set with alloc_req[0]
- alloc_gnt  out  1  all requested slots granted this cycle
- alloc_tag  out  SCALAR x PREG_W  tag for slot i, valid when alloc_gnt && alloc_req[i]
- retire_valid  in  SCALAR  retiring instruction with a destination register
- retire_told  in  SCALAR x PREG_W  stale tag to return to the list
- free_cnt  out  PTR_W  number of tags currently in the list
- overflow_err  out  1  sticky; set when a free is attempted while the list is full
- stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Storage: circular array fl[DEPTH] of PREG_W bits. State: head, tail, arch_head, each PTR_W wide.
- free_cnt = tail - head, modulo 2^PTR_W.
- Reset (synchronous, highest priority):
  - fl[i] = ARCH_REGS+i.
  - head = arch_head = 0; tail = {1'b1, 0} (list full).
  - free_cnt = DEPTH; alloc_gnt = 0 during reset; overflow_err = 0; stall_cycles = 0.
- Allocation (combinational outputs, state update at the clock edge):
  - n_req = popcount(alloc_req).
  - alloc_gnt = !reset && !rollback && (free_cnt >= n_req). With n_req = 0, alloc_gnt = 1.
  - alloc_tag[i] = fl[(head+i) mod DEPTH].
  - On the edge: if alloc_gnt, head += n_req.
  - Grant is all-or-nothing: if the check fails, head is unchanged and rename stalls.
- Free (retire):
  - k = popcount(retire_valid).
  - Valid entries are written in slot order to fl[tail], fl[tail+1]; tail += k.
  - Each valid retire also advances arch_head by 1 (arch_head += k). A retiring instruction consumed one allocation.
- Same-cycle interactions:
  - Tags freed in cycle t are not visible to alloc_gnt/alloc_tag until t+1; there is no bypass.
  - Alloc and free in the same cycle are both applied. free_cnt(t+1) = free_cnt(t) - granted + k.
- Rollback (priority over alloc):
  - No grant in that cycle.
  - Retires in the same cycle are still applied.
  - head <= arch_head + k. All speculatively allocated tags return to the list.
  - tail and fl contents are otherwise untouched.
- Full/overflow: if free_cnt + k > DEPTH, the excess write is dropped, tail saturates at head+DEPTH, and overflow_err is set until reset. This condition is illegal; the bench flags it.
- Wrap-around: all pointer arithmetic is modulo 2^PTR_W; array index = ptr[PTR_W-2:0].
- Reset mid-operation: reset overrides rollback, alloc and retire in the same cycle.

Optional Feature:
- Macro: FREELIST_PERF_CNT_EN.
- Defined: stall_cycles increments (saturating at 2^32-1) every cycle with n_req>0 && !alloc_gnt && !rollback. It is cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset, then alloc_req=2'b11 for one cycle -> alloc_gnt=1, alloc_tag={33,32}; next cycle free_cnt=30.
- Grant 16 pairs back-to-back -> tags 32..63 in order; free_cnt=0. Next alloc_req=2'b01 -> alloc_gnt=0; stall_cycles=1 with the macro defined, 0 without.
- With free_cnt=0, retire_valid=2'b11, told={5,7} plus alloc_req=2'b01 in the same cycle -> alloc_gnt=0. Next cycle alloc_tag[0]=7, free_cnt=2.
- Allocate 6 tags, retire 2 (told={1,2}), then rollback with retire_valid=2'b01 (told=3) -> head=arch_head=3; free_cnt=32-3+3=32; alloc_gnt=0 on the rollback cycle.
- Run 40 alloc/retire pairs crossing index 31->0 -> tag order preserved across the wrap; free_cnt stays 32 - in-flight count.
- At reset state (full), retire_valid=2'b01 -> overflow_err=1, free_cnt stays 32. Assert reset -> overflow_err=0.
